// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port SRAM arbiter.
//   state_t  : arbiter FSM encoding (IDLE, ACCESS, RESP)
//   req_id_t : requester identity (ID_A, ID_B), used for the winner and last_served
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/sram_arbiter_2port_if.sv
// Requester-side bundle of the two-port SRAM arbiter.
//   req_x / we_x / addr_x / wdata_x : request from requester A or B
//                                     (held stable until ack_x)
//   ack_x                           : one-cycle completion pulse
//   rdata_x                         : read result, valid with ack_x on a read
//   busy                            : arbiter is not idle
// master = requester side, slave = arbiter side.
interface sram_arbiter_2port_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              ack_a;
  logic              ack_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              busy;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  ack_a, ack_b, rdata_a, rdata_b, busy
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output ack_a, ack_b, rdata_a, rdata_b, busy
  );

endinterface

// File: rtl/rr_pick_2.sv
// Two-way round-robin picker, purely combinational.
//   req_a, req_b : pending requests
//   last_served  : requester granted most recently
//   valid        : at least one request pending
//   winner       : granted requester (meaningful only when valid)
// A lone request always wins; on a tie the requester not served last wins.
module rr_pick_2
  import sram_arb_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last_served,
  output logic    valid,
  output req_id_t winner
);

  always_comb begin
    valid  = req_a | req_b;
    winner = ID_A;
    if (req_a && req_b) begin
      winner = (last_served == ID_A) ? ID_B : ID_A;
    end else if (req_b) begin
      winner = ID_B;
    end
  end

endmodule

// File: rtl/sram_arbiter_2port.sv
// Two-requester arbiter in front of a single-port SRAM (sram_8bit_1024 style:
// wr_en, rd_en, addr, bidirectional data).
//   clk, reset_p   : clock; asynchronous active-high reset
//   bus (slave)    : requester A/B handshake, read data, busy
//   sram_wr_en     : SRAM write strobe (ACCESS cycle of a write)
//   sram_rd_en     : SRAM read strobe (ACCESS cycle of a read)
//   sram_addr      : latched access address
//   sram_data      : driven only during a write ACCESS, otherwise released
// Each access runs IDLE -> ACCESS -> RESP -> IDLE, one cycle per non-idle
// state, so a held request is served once every three cycles.
module sram_arbiter_2port
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_p,
  sram_arbiter_2port_if.slave   bus,
  output logic                  sram_wr_en,
  output logic                  sram_rd_en,
  output logic [ADDR_W-1:0]     sram_addr,
  inout  wire  [DATA_W-1:0]     sram_data
);

  state_t            state;
  state_t            state_d;
  req_id_t           last_served;
  req_id_t           win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_a_q;
  logic [DATA_W-1:0] rdata_b_q;
  logic              data_oe;

  logic              pick_valid;
  req_id_t           pick_winner;

  rr_pick_2 u_pick (
    .req_a       (bus.req_a),
    .req_b       (bus.req_b),
    .last_served (last_served),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  // Requests are only looked at in IDLE; once latched, the request lines are
  // ignored until the access completes.
  logic grant;
  assign grant = (state == IDLE) && pick_valid;

  // State register plus latched request and read-data registers.
  // NOTE: datapath registers are reset too, because sram_addr and rdata_x
  // must read 0 straight out of reset.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state       <= IDLE;
      last_served <= ID_B;
      win_q       <= ID_A;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // present before the edge, independent of statement order.
      state <= state_d;
      if (grant) begin
        win_q       <= pick_winner;
        last_served <= pick_winner;
        if (pick_winner == ID_A) begin
          we_q    <= bus.we_a;
          addr_q  <= bus.addr_a;
          wdata_q <= bus.wdata_a;
        end else begin
          we_q    <= bus.we_b;
          addr_q  <= bus.addr_b;
          wdata_q <= bus.wdata_b;
        end
      end
      // Read data is captured from the SRAM on the ACCESS -> RESP edge.
      if ((state == ACCESS) && !we_q) begin
        if (win_q == ID_A) begin
          rdata_a_q <= sram_data;
        end else begin
          rdata_b_q <= sram_data;
        end
      end
    end
  end

  // Next state and all state-decoded outputs. Strobes depend only on the
  // current state, so an asynchronous reset drops them immediately.
  always_comb begin
    // NOTE: every output gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    state_d    = state;
    sram_wr_en = 1'b0;
    sram_rd_en = 1'b0;
    data_oe    = 1'b0;
    bus.ack_a  = 1'b0;
    bus.ack_b  = 1'b0;
    bus.busy   = 1'b1;
    unique case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (pick_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        sram_wr_en = we_q;
        sram_rd_en = !we_q;
        data_oe    = we_q;
        state_d    = RESP;
      end
      RESP: begin
        bus.ack_a = (win_q == ID_A);
        bus.ack_b = (win_q == ID_B);
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sram_addr   = addr_q;
  assign sram_data   = data_oe ? wdata_q : 'z;
  assign bus.rdata_a = rdata_a_q;
  assign bus.rdata_b = rdata_b_q;

endmodule
